// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch block.
// FSM state encodings live here so the top and any bench can agree on them.
package instr_fetch_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_REQ  = 3'd1;
    localparam state_t S_WAIT = 3'd2;
    localparam state_t S_HOLD = 3'd3;
    localparam state_t S_DROP = 3'd4;

    localparam int WIDTH_DEFAULT  = 32;
    localparam int BYTES_PER_WORD = WIDTH_DEFAULT / 8;

endpackage

// File: rtl/instr_fetch_out_reg.sv
// Valid/ready holding register between fetch and decode.
// A load takes priority over a same-cycle consume so a new entry is never lost.
module instr_fetch_out_reg
    import instr_fetch_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_instr,
    input  logic [WIDTH-1:0] i_pc,
    input  logic             i_misalign,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_instr,
    output logic [WIDTH-1:0] o_pc,
    output logic             o_misalign
);

    logic             r_valid;
    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] r_pc;
    logic             r_misalign;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_instr    <= '0;
            r_pc       <= '0;
            r_misalign <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_instr    <= i_instr;
            r_pc       <= i_pc;
            r_misalign <= i_misalign;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid    = r_valid;
    assign o_instr    = r_instr;
    assign o_pc       = r_pc;
    assign o_misalign = r_misalign;

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch FSM with flush and decode backpressure.
// Optional misaligned-pc trap path enabled by INSTR_FETCH_ALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for a pc, pc_ready high
// REQ   | request presented, waiting for grant
// WAIT  | granted, waiting for read data
// HOLD  | instruction presented to decode, waiting for instr_ready
// DROP  | flushed with a response still outstanding; swallow it
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_pc,
    input  logic             i_pc_valid,
    output logic             o_pc_ready,
    input  logic             i_flush,
    output logic             o_imem_req,
    output logic [WIDTH-1:0] o_imem_addr,
    input  logic             i_imem_gnt,
    input  logic             i_imem_rvalid,
    input  logic [WIDTH-1:0] i_imem_rdata,
    output logic             o_instr_valid,
    output logic [WIDTH-1:0] o_instr,
    output logic [WIDTH-1:0] o_instr_pc,
    input  logic             i_instr_ready,
    output logic             o_misalign
);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_addr;

    logic             w_accept;
    logic             w_capture;
    logic             w_load;
    logic             w_clear;
    logic             w_misaligned;
    logic             w_load_mis;
    logic [WIDTH-1:0] w_load_instr;
    logic [WIDTH-1:0] w_load_pc;

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    localparam int               BPW        = WIDTH / 8;
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(BPW - 1);
    assign w_misaligned = (i_pc & ALIGN_MASK) != '0;
`else
    assign w_misaligned = 1'b0;
`endif

    // Flush wins over everything, including a pending decode handshake.
    assign o_pc_ready = !reset && !i_flush &&
                        ((r_state == S_IDLE) || ((r_state == S_HOLD) && i_instr_ready));
    assign w_accept    = i_pc_valid && o_pc_ready;
    assign o_imem_req  = !reset && (r_state == S_REQ);
    assign o_imem_addr = r_addr;

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_load       = 1'b0;
        w_clear      = 1'b0;
        w_load_mis   = 1'b0;
        w_load_instr = i_imem_rdata;
        w_load_pc    = r_addr;

        case (r_state)
            S_IDLE: begin
                if (i_flush) w_clear = 1'b1;
            end
            S_REQ: begin
                if (i_flush)         w_next_state = i_imem_gnt ? S_DROP : S_IDLE;
                else if (i_imem_gnt) w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (i_flush) begin
                    w_next_state = i_imem_rvalid ? S_IDLE : S_DROP;
                end else if (i_imem_rvalid) begin
                    w_load       = 1'b1;
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (i_flush) begin
                    w_clear      = 1'b1;
                    w_next_state = S_IDLE;
                end else if (i_instr_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            S_DROP: begin
                if (i_imem_rvalid) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase

        // Accepting a pc from IDLE or from a HOLD handshake is handled in one place.
        if (w_accept) begin
            w_capture    = 1'b1;
            w_next_state = S_REQ;
            if (w_misaligned) begin
                w_load       = 1'b1;
                w_load_instr = '0;
                w_load_pc    = i_pc;
                w_load_mis   = 1'b1;
                w_next_state = S_HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) r_addr <= i_pc;
        end
    end

    instr_fetch_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_clear),
        .i_load     (w_load),
        .i_instr    (w_load_instr),
        .i_pc       (w_load_pc),
        .i_misalign (w_load_mis),
        .i_ready    (i_instr_ready),
        .o_valid    (o_instr_valid),
        .o_instr    (o_instr),
        .o_pc       (o_instr_pc),
        .o_misalign (o_misalign)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; alignment test follows
// INSTR_FETCH_ALIGN_CHECK_EN.
module tb_instr_fetch;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic [W-1:0] pc;
    logic         pc_valid;
    logic         pc_ready;
    logic         flush;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         imem_gnt;
    logic         imem_rvalid;
    logic [W-1:0] imem_rdata;
    logic         instr_valid;
    logic [W-1:0] instr;
    logic [W-1:0] instr_pc;
    logic         instr_ready;
    logic         misalign;

    int n_pass;
    int n_total;

    instr_fetch #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_pc          (pc),
        .i_pc_valid    (pc_valid),
        .o_pc_ready    (pc_ready),
        .i_flush       (flush),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_gnt    (imem_gnt),
        .i_imem_rvalid (imem_rvalid),
        .i_imem_rdata  (imem_rdata),
        .o_instr_valid (instr_valid),
        .o_instr       (instr),
        .o_instr_pc    (instr_pc),
        .i_instr_ready (instr_ready),
        .o_misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic quiet();
        pc_valid = 1'b0; flush = 1'b0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; pc = 32'h10; pc_valid = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hFFFF;
        sample();
        n_total++; if (pc_ready !== 1'b0) $display("FAIL reset_pc_ready got=%0h exp=0", pc_ready); else n_pass++;
        n_total++; if (imem_req !== 1'b0) $display("FAIL reset_imem_req got=%0h exp=0", imem_req); else n_pass++;
        n_total++; if ({instr_valid, misalign, instr, instr_pc, imem_addr} !== '0)
            $display("FAIL reset_outputs got=%0h/%0h/%0h/%0h/%0h exp=0", instr_valid, misalign, instr, instr_pc, imem_addr);
        else n_pass++;
        step();
        reset = 1'b0; quiet();
        sample();
        n_total++; if (pc_ready !== 1'b1) $display("FAIL reset_idle_ready got=%0h exp=1", pc_ready); else n_pass++;
        step();
    endtask

    task automatic test_single_fetch();
        quiet(); pc = 32'h10; pc_valid = 1'b1;
        sample();
        n_total++; if (pc_ready !== 1'b1) $display("FAIL single_accept got=%0h exp=1", pc_ready); else n_pass++;
        step();
        pc_valid = 1'b0; imem_gnt = 1'b1;
        sample();
        n_total++; if ({imem_req, imem_addr} !== {1'b1, 32'h10})
            $display("FAIL single_req got=%0h/%0h exp=1/10", imem_req, imem_addr); else n_pass++;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
        sample();
        n_total++; if ({imem_req, instr_valid} !== 2'b00)
            $display("FAIL single_wait got=%0h/%0h exp=0/0", imem_req, instr_valid); else n_pass++;
        step();
        imem_rvalid = 1'b0; imem_rdata = '0;
        sample();
        n_total++; if ({instr_valid, instr, instr_pc, misalign} !== {1'b1, 32'hDEADBEEF, 32'h10, 1'b0})
            $display("FAIL single_instr got=%0h/%0h/%0h/%0h exp=1/deadbeef/10/0", instr_valid, instr, instr_pc, misalign);
        else n_pass++;
        step();
        sample();
        n_total++; if ({instr_valid, pc_ready} !== 2'b01)
            $display("FAIL single_done got=%0h/%0h exp=0/1", instr_valid, pc_ready); else n_pass++;
    endtask

    task automatic test_backpressure();
        quiet(); instr_ready = 1'b0; pc = 32'h30; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0; imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hCAFEF00D;
        step();
        imem_rvalid = 1'b0; pc = 32'h14; pc_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            n_total++; if ({instr_valid, instr, instr_pc, pc_ready, imem_req} !== {1'b1, 32'hCAFEF00D, 32'h30, 1'b0, 1'b0})
                $display("FAIL bp_hold[%0d] got=%0h/%0h/%0h/%0h/%0h exp=1/cafef00d/30/0/0",
                         i, instr_valid, instr, instr_pc, pc_ready, imem_req);
            else n_pass++;
            step();
        end
        instr_ready = 1'b1;
        sample();
        n_total++; if (pc_ready !== 1'b1) $display("FAIL bp_handshake_ready got=%0h exp=1", pc_ready); else n_pass++;
        step();
        pc_valid = 1'b0; imem_gnt = 1'b1;
        sample();
        n_total++; if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h14, 1'b0})
            $display("FAIL bp_next_req got=%0h/%0h/%0h exp=1/14/0", imem_req, imem_addr, instr_valid); else n_pass++;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h5555;
        step();
        imem_rvalid = 1'b0;
        sample();
        n_total++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h5555, 32'h14})
            $display("FAIL bp_second got=%0h/%0h/%0h exp=1/5555/14", instr_valid, instr, instr_pc); else n_pass++;
        step();
    endtask

    task automatic test_stalled_grant();
        quiet(); pc = 32'h20; pc_valid = 1'b1;
        step();
        pc = 32'h99;
        for (int i = 0; i < 5; i++) begin
            sample();
            n_total++; if ({imem_req, imem_addr, pc_ready} !== {1'b1, 32'h20, 1'b0})
                $display("FAIL stall_req[%0d] got=%0h/%0h/%0h exp=1/20/0", i, imem_req, imem_addr, pc_ready);
            else n_pass++;
            step();
        end
        pc_valid = 1'b0; imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2020;
        step();
        imem_rvalid = 1'b0;
        sample();
        n_total++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h2020, 32'h20})
            $display("FAIL stall_instr got=%0h/%0h/%0h exp=1/2020/20", instr_valid, instr, instr_pc); else n_pass++;
        step();
    endtask

    task automatic test_flush_wait();
        quiet(); pc = 32'h30; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0; imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; flush = 1'b1;
        sample();
        n_total++; if (pc_ready !== 1'b0) $display("FAIL fw_flush_ready got=%0h exp=0", pc_ready); else n_pass++;
        step();
        flush = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111; pc = 32'h40; pc_valid = 1'b1;
        sample();
        n_total++; if ({pc_ready, imem_req, instr_valid} !== 3'b000)
            $display("FAIL fw_drop got=%0h/%0h/%0h exp=0/0/0", pc_ready, imem_req, instr_valid); else n_pass++;
        step();
        imem_rvalid = 1'b0; imem_rdata = '0;
        sample();
        n_total++; if ({instr_valid, pc_ready} !== 2'b01)
            $display("FAIL fw_idle got=%0h/%0h exp=0/1", instr_valid, pc_ready); else n_pass++;
        step();
        pc_valid = 1'b0; imem_gnt = 1'b1;
        sample();
        n_total++; if ({imem_req, imem_addr} !== {1'b1, 32'h40})
            $display("FAIL fw_refetch_req got=%0h/%0h exp=1/40", imem_req, imem_addr); else n_pass++;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h4040;
        step();
        imem_rvalid = 1'b0;
        sample();
        n_total++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h4040, 32'h40})
            $display("FAIL fw_refetch got=%0h/%0h/%0h exp=1/4040/40", instr_valid, instr, instr_pc); else n_pass++;
        step();
    endtask

    task automatic test_flush_other();
        // flush in WAIT together with rvalid: straight back to IDLE, data dropped
        quiet(); pc = 32'h50; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0; imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; flush = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h5050;
        step();
        quiet();
        sample();
        n_total++; if ({instr_valid, pc_ready} !== 2'b01)
            $display("FAIL fwr_idle got=%0h/%0h exp=0/1", instr_valid, pc_ready); else n_pass++;
        // flush in REQ with grant: DROP until the stray response returns
        pc = 32'h60; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0; imem_gnt = 1'b1; flush = 1'b1;
        step();
        quiet();
        for (int i = 0; i < 2; i++) begin
            sample();
            n_total++; if ({pc_ready, imem_req} !== 2'b00)
                $display("FAIL frg_drop[%0d] got=%0h/%0h exp=0/0", i, pc_ready, imem_req); else n_pass++;
            step();
        end
        imem_rvalid = 1'b1; imem_rdata = 32'h6060;
        step();
        imem_rvalid = 1'b0;
        sample();
        n_total++; if ({instr_valid, pc_ready} !== 2'b01)
            $display("FAIL frg_exit got=%0h/%0h exp=0/1", instr_valid, pc_ready); else n_pass++;
        // flush while holding an instruction for decode
        instr_ready = 1'b0; pc = 32'h70; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0; imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h7070;
        step();
        imem_rvalid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        sample();
        n_total++; if ({instr_valid, pc_ready} !== 2'b01)
            $display("FAIL fh_idle got=%0h/%0h exp=0/1", instr_valid, pc_ready); else n_pass++;
        // rvalid arriving in IDLE is ignored
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD;
        step();
        imem_rvalid = 1'b0;
        sample();
        n_total++; if (instr_valid !== 1'b0) $display("FAIL idle_rvalid got=%0h exp=0", instr_valid); else n_pass++;
        instr_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        quiet(); pc = 32'h100; pc_valid = 1'b1;
        step();
        pc = 32'h104; imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA0A0;
        step();
        imem_rvalid = 1'b0;
        sample();
        n_total++; if ({instr_valid, instr, instr_pc, pc_ready} !== {1'b1, 32'hA0A0, 32'h100, 1'b1})
            $display("FAIL b2b_first got=%0h/%0h/%0h/%0h exp=1/a0a0/100/1", instr_valid, instr, instr_pc, pc_ready);
        else n_pass++;
        step();
        pc_valid = 1'b0; imem_gnt = 1'b1;
        sample();
        n_total++; if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h104, 1'b0})
            $display("FAIL b2b_req got=%0h/%0h/%0h exp=1/104/0", imem_req, imem_addr, instr_valid); else n_pass++;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hB0B0;
        step();
        imem_rvalid = 1'b0;
        sample();
        n_total++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'hB0B0, 32'h104})
            $display("FAIL b2b_second got=%0h/%0h/%0h exp=1/b0b0/104", instr_valid, instr, instr_pc); else n_pass++;
        step();
    endtask

    task automatic test_reset_mid();
        quiet(); pc = 32'h80; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0; imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h8080;
        step();
        imem_rvalid = 1'b0;
        sample();
        n_total++; if ({instr_valid, pc_ready, imem_req} !== 3'b010)
            $display("FAIL rst_mid got=%0h/%0h/%0h exp=0/1/0", instr_valid, pc_ready, imem_req); else n_pass++;
        step();
    endtask

    task automatic test_align();
        quiet(); pc = 32'h22; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0; instr_ready = 1'b0;
        sample();
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
        n_total++; if ({imem_req, instr_valid, misalign, instr, instr_pc} !== {1'b0, 1'b1, 1'b1, 32'h0, 32'h22})
            $display("FAIL align_trap got=%0h/%0h/%0h/%0h/%0h exp=0/1/1/0/22",
                     imem_req, instr_valid, misalign, instr, instr_pc);
        else n_pass++;
        instr_ready = 1'b1;
        step();
`else
        n_total++; if ({imem_req, imem_addr, misalign} !== {1'b1, 32'h22, 1'b0})
            $display("FAIL align_off got=%0h/%0h/%0h exp=1/22/0", imem_req, imem_addr, misalign); else n_pass++;
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2222;
        step();
        imem_rvalid = 1'b0; instr_ready = 1'b1;
        sample();
        n_total++; if ({instr_valid, instr, misalign} !== {1'b1, 32'h2222, 1'b0})
            $display("FAIL align_off_instr got=%0h/%0h/%0h exp=1/2222/0", instr_valid, instr, misalign); else n_pass++;
        step();
`endif
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        reset = 1'b1; pc = '0; quiet();
        step();
        test_reset();
        test_single_fetch();
        test_backpressure();
        test_stalled_grant();
        test_flush_wait();
        test_flush_other();
        test_back_to_back();
        test_reset_mid();
        test_align();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
